// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ID/EX issue stage.
//   - ALU_* : 4-bit ALU control codes driven to the EX-stage ALU
//   - OP_*, F3_*, F7_* : RV32 opcode / funct3 / funct7 field values
//   - op2_sel_e : source of ALU operand 2
//   - dec_t : decoder result consumed by the EX register
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_XOR  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_MUL  = 4'b0101;
  localparam logic [3:0] ALU_ADDI = 4'b0110;
  localparam logic [3:0] ALU_SRAI = 4'b0111;
  localparam logic [3:0] ALU_LW   = 4'b1000;
  localparam logic [3:0] ALU_SW   = 4'b1001;
  localparam logic [3:0] ALU_BEQ  = 4'b1010;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRA     = 3'b101;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    OP2_RS2   = 2'd0,
    OP2_IMM_I = 2'd1,
    OP2_SHAMT = 2'd2,
    OP2_IMM_S = 2'd3
  } op2_sel_e;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    op2_sel_e   op2_sel;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: producer-side bus of the issue stage.
//   Upstream -> stage : valid_i, instr_i, rs1_data_i, rs2_data_i, stall_i, flush_i
//   Stage -> EX/ALU   : ready_o, valid_o, ALUCtrl_o, data1_o, data2_o,
//                       store_data_o, rd_o, RegWrite_o, MemRead_o,
//                       MemWrite_o, Branch_o, illegal_o
// Handshake: an instruction transfers on a rising edge where valid_i && ready_o
// && !flush_i; ready_o may drop with no valid_i dependence, and upstream must
// hold instr_i / rs*_data_i stable while valid_i is high and ready_o is low.
interface alu_issue_stage_if;
  logic        valid_i;
  logic [31:0] instr_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        stall_i;
  logic        flush_i;
  logic        ready_o;
  logic        valid_o;
  logic [3:0]  ALUCtrl_o;
  logic [31:0] data1_o;
  logic [31:0] data2_o;
  logic [31:0] store_data_o;
  logic [4:0]  rd_o;
  logic        RegWrite_o;
  logic        MemRead_o;
  logic        MemWrite_o;
  logic        Branch_o;
  logic        illegal_o;

  modport master (
    output valid_i, instr_i, rs1_data_i, rs2_data_i, stall_i, flush_i,
    input  ready_o, valid_o, ALUCtrl_o, data1_o, data2_o, store_data_o, rd_o,
           RegWrite_o, MemRead_o, MemWrite_o, Branch_o, illegal_o
  );

  modport slave (
    input  valid_i, instr_i, rs1_data_i, rs2_data_i, stall_i, flush_i,
    output ready_o, valid_o, ALUCtrl_o, data1_o, data2_o, store_data_o, rd_o,
           RegWrite_o, MemRead_o, MemWrite_o, Branch_o, illegal_o
  );
endinterface

// File: rtl/alu_decode.sv
// alu_decode: combinational RV32 instruction decoder.
//   i_instr : instruction word
//   o_dec   : ALU code, operand-2 select, control bits, illegal flag
//   o_imm   : immediate for the selected operand-2 format
//   o_rd    : destination register (0 for sw/beq)
import alu_pkg::*;

module alu_decode (
  input  logic [31:0] i_instr,
  output dec_t        o_dec,
  output logic [31:0] o_imm,
  output logic [4:0]  o_rd
);
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_unused_rs1_idx;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  // The rs1 index is consumed by the register file; operand values arrive on rs1_data_i.
  assign w_unused_rs1_idx = ^i_instr[19:15];

  always_comb begin
    o_dec          = '0;
    o_dec.alu_ctrl = ALU_AND;
    o_dec.op2_sel  = OP2_RS2;
    o_dec.illegal  = 1'b1;
    case (w_opcode)
      OP_RTYPE: begin
        o_dec.illegal   = 1'b0;
        o_dec.reg_write = 1'b1;
        case ({w_funct7, w_funct3})
          {F7_BASE,   F3_AND}:     o_dec.alu_ctrl = ALU_AND;
          {F7_BASE,   F3_XOR}:     o_dec.alu_ctrl = ALU_XOR;
          {F7_BASE,   F3_SLL}:     o_dec.alu_ctrl = ALU_SLL;
          {F7_BASE,   F3_ADD_SUB}: o_dec.alu_ctrl = ALU_ADD;
          {F7_ALT,    F3_ADD_SUB}: o_dec.alu_ctrl = ALU_SUB;
          {F7_MULDIV, F3_ADD_SUB}: o_dec.alu_ctrl = ALU_MUL;
          default: begin
            o_dec.illegal   = 1'b1;
            o_dec.reg_write = 1'b0;
          end
        endcase
      end
      OP_IMM: begin
        if (w_funct3 == F3_ADD_SUB) begin
          o_dec.illegal   = 1'b0;
          o_dec.reg_write = 1'b1;
          o_dec.alu_ctrl  = ALU_ADDI;
          o_dec.op2_sel   = OP2_IMM_I;
        end else if (w_funct3 == F3_SRA && w_funct7 == F7_ALT) begin
          o_dec.illegal   = 1'b0;
          o_dec.reg_write = 1'b1;
          o_dec.alu_ctrl  = ALU_SRAI;
          o_dec.op2_sel   = OP2_SHAMT;
        end
      end
      OP_LOAD: begin
        if (w_funct3 == F3_LW) begin
          o_dec.illegal   = 1'b0;
          o_dec.reg_write = 1'b1;
          o_dec.mem_read  = 1'b1;
          o_dec.alu_ctrl  = ALU_LW;
          o_dec.op2_sel   = OP2_IMM_I;
        end
      end
      OP_STORE: begin
        if (w_funct3 == F3_SW) begin
          o_dec.illegal   = 1'b0;
          o_dec.mem_write = 1'b1;
          o_dec.alu_ctrl  = ALU_SW;
          o_dec.op2_sel   = OP2_IMM_S;
        end
      end
      OP_BRANCH: begin
        if (w_funct3 == F3_BEQ) begin
          o_dec.illegal  = 1'b0;
          o_dec.branch   = 1'b1;
          o_dec.alu_ctrl = ALU_BEQ;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    o_imm = '0;
    case (o_dec.op2_sel)
      OP2_IMM_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      OP2_SHAMT: o_imm = {27'd0, i_instr[24:20]};
      OP2_IMM_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      default:   o_imm = '0;
    endcase
  end

  // sw and beq reuse instr[11:7] for immediate bits, so no destination is reported.
  assign o_rd = (o_dec.mem_write || o_dec.branch) ? 5'd0 : i_instr[11:7];

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue register feeding the ALU.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : alu_issue_stage_if.slave (upstream inputs, EX-register outputs)
// Parameter MUL_CYCLES (2..16): EX occupancy of mul in multi-cycle builds.
// Build option ALU_MUL_MULTICYCLE_EN: when defined, a captured mul holds the EX
// register for MUL_CYCLES cycles and ready_o stays low meanwhile; when
// undefined, mul retires in one cycle like every other op.
import alu_pkg::*;

module alu_issue_stage #(
  parameter int MUL_CYCLES = 4
) (
  input logic             clk_i,
  input logic             rst_i,
  alu_issue_stage_if.slave bus
);
  dec_t        w_dec;
  logic [31:0] w_imm;
  logic [4:0]  w_rd;
  logic [31:0] w_op2;
  logic        w_busy;
  logic        w_advance;

  logic        r_valid;
  logic        r_illegal;
  logic [3:0]  r_alu_ctrl;
  logic [31:0] r_data1;
  logic [31:0] r_data2;
  logic [31:0] r_store_data;
  logic [4:0]  r_rd;
  logic        r_reg_write;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_branch;

  if (MUL_CYCLES < 2 || MUL_CYCLES > 16) begin : g_bad_mul_cycles
    $error("alu_issue_stage: MUL_CYCLES must be within 2..16");
  end

  alu_decode u_decode (
    .i_instr (bus.instr_i),
    .o_dec   (w_dec),
    .o_imm   (w_imm),
    .o_rd    (w_rd)
  );

  assign w_op2     = (w_dec.op2_sel == OP2_RS2) ? bus.rs2_data_i : w_imm;
  assign w_advance = !bus.stall_i && !w_busy;
  assign bus.ready_o = w_advance;

`ifdef ALU_MUL_MULTICYCLE_EN
  logic [3:0] r_busy_cnt;

  // The counter free-runs down even under stall: mul occupancy is wall-clock
  // cycles of the ALU, not cycles of forward progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy_cnt <= '0;
    end else if (bus.flush_i) begin
      r_busy_cnt <= '0;
    end else if (r_busy_cnt != 4'd0) begin
      r_busy_cnt <= r_busy_cnt - 4'd1;
    end else if (w_advance && bus.valid_i && !w_dec.illegal && w_dec.alu_ctrl == ALU_MUL) begin
      r_busy_cnt <= 4'(MUL_CYCLES - 1);
    end
  end

  assign w_busy = (r_busy_cnt != 4'd0);
`else
  assign w_busy = 1'b0;
`endif

  // Bubbles (flush, or advance with no valid input) clear the whole register so
  // downstream never sees stale operands tagged with a live-looking code.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid      <= 1'b0;
      r_illegal    <= 1'b0;
      r_alu_ctrl   <= ALU_AND;
      r_data1      <= '0;
      r_data2      <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
    end else if (bus.flush_i || (w_advance && !bus.valid_i)) begin
      r_valid      <= 1'b0;
      r_illegal    <= 1'b0;
      r_alu_ctrl   <= ALU_AND;
      r_data1      <= '0;
      r_data2      <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
    end else if (w_advance) begin
      r_valid      <= 1'b1;
      r_illegal    <= w_dec.illegal;
      r_alu_ctrl   <= w_dec.alu_ctrl;
      r_data1      <= bus.rs1_data_i;
      r_data2      <= w_op2;
      // rs2 is carried for every op; only sw consumes it downstream.
      r_store_data <= bus.rs2_data_i;
      r_rd         <= w_rd;
      r_reg_write  <= w_dec.reg_write;
      r_mem_read   <= w_dec.mem_read;
      r_mem_write  <= w_dec.mem_write;
      r_branch     <= w_dec.branch;
    end
  end

  assign bus.valid_o      = r_valid;
  assign bus.illegal_o    = r_illegal;
  assign bus.ALUCtrl_o    = r_alu_ctrl;
  assign bus.data1_o      = r_data1;
  assign bus.data2_o      = r_data2;
  assign bus.store_data_o = r_store_data;
  assign bus.rd_o         = r_rd;
  assign bus.RegWrite_o   = r_reg_write;
  assign bus.MemRead_o    = r_mem_read;
  assign bus.MemWrite_o   = r_mem_write;
  assign bus.Branch_o     = r_branch;

endmodule
